// File: rtl/keypad_entry_if.sv
// Signal bundle between the keypad scanner and its consumers (keypad matrix,
// 7-segment display driver). The scanner is the master side.
`timescale 1ns/1ps
interface keypad_entry_if;
  logic [3:0]  COL;
  logic [3:0]  ROW;
  logic [15:0] dat;
  logic [1:0]  ptr_P;
  logic [3:0]  key_code;
  logic        key_vld;
  logic        ce1ms;

  modport master (output COL, input ROW, output dat, output ptr_P,
                  output key_code, output key_vld, output ce1ms);
  modport slave  (input COL, output ROW, input dat, input ptr_P,
                  input key_code, input key_vld, input ce1ms);
endinterface

// File: rtl/keypad_entry.sv
// 4x4 hex keypad scanner: one column driven low per slot, debounced presses
// are shifted into a 16-bit hex word for the display driver.
`timescale 1ns/1ps
module keypad_entry #(
  parameter int Fclk  = 50000,
  parameter int F1kHz = 1,
  parameter int DEB   = 4
) (
  input  logic           clk,
  input  logic           rst,
  keypad_entry_if.master kp
);
  localparam int SLOT = Fclk / F1kHz;
  localparam int CBW  = $clog2(SLOT + 1);

  typedef enum logic [1:0] {S_IDLE, S_DEB, S_PRESSED, S_REL} state_t;

  logic [CBW-1:0] cb_1ms_reg;
  logic           ce;
  logic           ce1ms_reg;
  logic [1:0]     cb_col_reg;
  logic [3:0]     col_reg;
  logic [3:0]     row_meta_reg;
  logic [3:0]     row_s_reg;
  logic [3:0]     frame_row_reg [4];
  logic [15:0]    frame;
  logic           frame_rdy_reg;
  logic [4:0]     n_set;
  logic [3:0]     code;
  logic           f_none;
  logic           f_single;
  state_t         state_reg, state_next;
  logic [3:0]     dcnt_reg, dcnt_next;
  logic [3:0]     cand_reg, cand_next;
  logic [4:0]     dcnt_inc;
  logic           reach;
  logic           accept;
  logic [3:0]     accept_code;
  logic [15:0]    dat_reg;
  logic [1:0]     ptr_reg;
  logic [3:0]     key_code_reg;
  logic           key_vld_reg;

  assign ce = (cb_1ms_reg == CBW'(SLOT));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cb_1ms_reg    <= '0;
      ce1ms_reg     <= 1'b0;
      cb_col_reg    <= 2'd0;
      col_reg       <= 4'b1110;
      row_meta_reg  <= 4'd0;
      row_s_reg     <= 4'd0;
      frame_rdy_reg <= 1'b0;
    end else begin
      cb_1ms_reg    <= ce ? CBW'(1) : cb_1ms_reg + 1'b1;
      ce1ms_reg     <= ce;
      if (ce)
        cb_col_reg  <= cb_col_reg + 2'd1;
      col_reg       <= ~(4'b0001 << cb_col_reg);
      row_meta_reg  <= kp.ROW;
      row_s_reg     <= row_meta_reg;
      frame_rdy_reg <= ce && (cb_col_reg == 2'd3);
    end
  end

  // The sample taken on ce belongs to the column driven during the slot now ending.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_row
      always_ff @(posedge clk or posedge rst) begin
        if (rst)
          frame_row_reg[gi] <= 4'd0;
        else if (ce)
          frame_row_reg[gi][cb_col_reg] <= ~row_s_reg[gi];
      end
      assign frame[4*gi +: 4] = frame_row_reg[gi];
    end
  endgenerate

  always_comb begin
    n_set = 5'd0;
    code  = 4'd0;
    for (int i = 0; i < 16; i++) begin
      if (frame[i]) begin
        n_set = n_set + 5'd1;
        code  = 4'(i);
      end
    end
  end

  assign f_none   = (n_set == 5'd0);
  assign f_single = (n_set == 5'd1);
  assign dcnt_inc = {1'b0, dcnt_reg} + 5'd1;
  assign reach    = (dcnt_inc == 5'(DEB));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= S_IDLE;
      dcnt_reg  <= 4'd0;
      cand_reg  <= 4'd0;
    end else begin
      state_reg <= state_next;
      dcnt_reg  <= dcnt_next;
      cand_reg  <= cand_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    dcnt_next  = dcnt_reg;
    cand_next  = cand_reg;
    if (frame_rdy_reg) begin
      case (state_reg)
        S_IDLE: if (f_single) begin
          cand_next  = code;
          dcnt_next  = 4'd1;
          state_next = (DEB == 1) ? S_PRESSED : S_DEB;
        end
        S_DEB: if (f_single && (code == cand_reg)) begin
          dcnt_next = dcnt_inc[3:0];
          if (reach)
            state_next = S_PRESSED;
        end else begin
          state_next = S_IDLE;
        end
        S_PRESSED: if (f_none) begin
          dcnt_next  = 4'd1;
          state_next = (DEB == 1) ? S_IDLE : S_REL;
        end
        S_REL: if (f_none) begin
          dcnt_next = dcnt_inc[3:0];
          if (reach)
            state_next = S_IDLE;
        end else begin
          state_next = S_PRESSED;
        end
        default: state_next = S_IDLE;
      endcase
    end
  end

  always_comb begin
    accept      = 1'b0;
    accept_code = cand_reg;
    if (frame_rdy_reg) begin
      case (state_reg)
        S_IDLE: if (f_single && (DEB == 1)) begin
          accept      = 1'b1;
          accept_code = code;
        end
        S_DEB: if (f_single && (code == cand_reg) && reach)
          accept = 1'b1;
        default: accept = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dat_reg      <= 16'd0;
      ptr_reg      <= 2'd0;
      key_code_reg <= 4'd0;
      key_vld_reg  <= 1'b0;
    end else begin
      key_vld_reg <= accept;
      if (accept) begin
        dat_reg      <= {dat_reg[11:0], accept_code};
        ptr_reg      <= ptr_reg + 2'd1;
        key_code_reg <= accept_code;
      end
    end
  end

  assign kp.COL      = col_reg;
  assign kp.dat      = dat_reg;
  assign kp.ptr_P    = ptr_reg;
  assign kp.key_code = key_code_reg;
  assign kp.key_vld  = key_vld_reg;
  assign kp.ce1ms    = ce1ms_reg;
endmodule

// File: tb/tb_keypad_entry.sv
// Bench for keypad_entry: directed scenarios plus random key frames, checked
// against a frame-level run-length model of press/release debouncing.
`timescale 1ns/1ps
module tb_keypad_entry;
  localparam int DEB = 2;

  logic        clk;
  logic        rst;
  logic [15:0] keys;
  logic [3:0]  row_drive;
  int          n_assert;
  int          n_fail;

  // reference model state
  bit          armed;
  int          run;
  int          rel_run;
  logic [3:0]  last_key;
  logic [15:0] m_dat;
  logic [1:0]  m_ptr;

  keypad_entry_if bus ();

  keypad_entry #(.Fclk(10), .F1kHz(1), .DEB(DEB)) dut (
    .clk(clk),
    .rst(rst),
    .kp (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // A held key shorts its row to its column while that column is driven low.
  always_comb begin
    row_drive = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[4*r + c] && !bus.COL[c])
          row_drive[r] = 1'b0;
  end
  assign bus.ROW = row_drive;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
    n_assert++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    end
  endtask

  task automatic model_reset();
    armed   = 1'b1;
    run     = 0;
    rel_run = 0;
    last_key = 4'd0;
    m_dat   = 16'd0;
    m_ptr   = 2'd0;
  endtask

  // A press is accepted once one key alone has been seen for DEB frames in a
  // row; a new press needs DEB empty frames in a row after that.
  task automatic model_frame(input logic [15:0] mask, output bit acc, output logic [3:0] k);
    int n;
    n   = $countones(mask);
    k   = 4'd0;
    acc = 1'b0;
    for (int i = 0; i < 16; i++)
      if (mask[i]) k = 4'(i);
    if (armed) begin
      if (n == 1 && (run == 0 || k == last_key)) begin
        run++;
        last_key = k;
      end else begin
        run = 0;
      end
      if (run == DEB) begin
        acc     = 1'b1;
        armed   = 1'b0;
        rel_run = 0;
        m_dat   = {m_dat[11:0], k};
        m_ptr   = m_ptr + 2'd1;
      end
    end else begin
      rel_run = (n == 0) ? rel_run + 1 : 0;
      if (rel_run == DEB) begin
        armed = 1'b1;
        run   = 0;
      end
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, " COL"}, 16'(bus.COL), 16'h000E);
    check({tag, " dat"}, bus.dat, 16'h0000);
    check({tag, " ptr_P"}, 16'(bus.ptr_P), 16'h0000);
    check({tag, " key_code"}, 16'(bus.key_code), 16'h0000);
    check({tag, " key_vld"}, 16'(bus.key_vld), 16'h0000);
    check({tag, " ce1ms"}, 16'(bus.ce1ms), 16'h0000);
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_reset_values(tag);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  // Apply one frame of keys, run to the next frame start, and compare.
  task automatic run_frame(input logic [15:0] mask, input string tag);
    int         pulses;
    logic [3:0] got_code;
    logic [3:0] prev_col;
    bit         done;
    bit         acc;
    logic [3:0] k;
    keys     = mask;
    pulses   = 0;
    got_code = 4'd0;
    prev_col = bus.COL;
    done     = 1'b0;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clk);
      if (bus.key_vld) begin
        pulses++;
        got_code = bus.key_code;
      end
      if (bus.COL == 4'b1110 && prev_col != 4'b1110) done = 1'b1;
      prev_col = bus.COL;
    end
    check({tag, " frame boundary"}, 16'(done), 16'd1);
    model_frame(mask, acc, k);
    check({tag, " key_vld count"}, 16'(pulses), acc ? 16'd1 : 16'd0);
    if (acc) check({tag, " key_code"}, 16'(got_code), 16'(k));
    check({tag, " dat"}, bus.dat, m_dat);
    check({tag, " ptr_P"}, 16'(bus.ptr_P), 16'(m_ptr));
    $display("frame %-10s keys=%h vld=%0d code=%h dat=%h ptr=%0d", tag, mask, pulses,
             got_code, bus.dat, bus.ptr_P);
  endtask

  initial begin
    logic [3:0]  col_seq [4];
    logic [3:0]  prev_col;
    logic [15:0] mask;
    logic [3:0]  k1;
    logic [3:0]  k2;
    int          since_col, since_ce, n_col, n_ce, vld_cnt, sel;

    n_assert = 0;
    n_fail   = 0;
    rst      = 1'b1;
    keys     = 16'd0;
    model_reset();
    col_seq[0] = 4'b1110; col_seq[1] = 4'b1101; col_seq[2] = 4'b1011; col_seq[3] = 4'b0111;

    // reset and idle scanning
    do_reset("reset");
    prev_col  = bus.COL;
    since_col = 0; since_ce = 0; n_col = 0; n_ce = 0; vld_cnt = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      since_col++;
      since_ce++;
      if (bus.key_vld) vld_cnt++;
      if (bus.COL != prev_col) begin
        n_col++;
        check("COL order", 16'(bus.COL), 16'(col_seq[n_col % 4]));
        if (n_col > 1) check("COL slot length", 16'(since_col), 16'd10);
        since_col = 0;
        prev_col  = bus.COL;
      end
      if (bus.ce1ms) begin
        n_ce++;
        if (n_ce > 1) check("ce1ms period", 16'(since_ce), 16'd10);
        since_ce = 0;
      end
    end
    check("idle key_vld", 16'(vld_cnt), 16'd0);
    check("idle ce1ms count", 16'(n_ce >= 38), 16'd1);

    // single press of B (row 2, column 3)
    do_reset("reset B");
    for (int f = 0; f < 6; f++) run_frame(16'h0800, "hold B");
    for (int f = 0; f < 3; f++) run_frame(16'h0000, "rel B");
    check("B dat", bus.dat, 16'h000B);
    check("B ptr_P", 16'(bus.ptr_P), 16'd1);

    // five digits with overflow
    do_reset("reset seq");
    for (int d = 1; d <= 5; d++) begin
      mask = 16'd1 << d;
      run_frame(mask, "press");
      run_frame(mask, "press");
      for (int f = 0; f < 3; f++) run_frame(16'h0000, "release");
      if (d == 4) begin
        check("four digits dat", bus.dat, 16'h1234);
        check("four digits ptr_P", 16'(bus.ptr_P), 16'd0);
      end
    end
    check("overflow dat", bus.dat, 16'h2345);
    check("overflow ptr_P", 16'(bus.ptr_P), 16'd1);

    // bouncing key 7, then hold with a one-frame release glitch
    do_reset("reset 7");
    for (int f = 0; f < 5; f++) run_frame((f % 2 == 0) ? 16'h0080 : 16'h0000, "bounce 7");
    for (int f = 0; f < 3; f++) run_frame(16'h0080, "hold 7");
    run_frame(16'h0000, "glitch 7");
    for (int f = 0; f < 2; f++) run_frame(16'h0080, "rehold 7");
    for (int f = 0; f < 3; f++) run_frame(16'h0000, "rel 7");
    check("bounce dat", bus.dat, 16'h0007);
    check("bounce ptr_P", 16'(bus.ptr_P), 16'd1);

    // multi-key frames
    do_reset("reset multi");
    for (int f = 0; f < 3; f++) run_frame(16'h0021, "keys 0+5");
    for (int f = 0; f < 3; f++) run_frame(16'h0000, "rel 0+5");
    check("multi dat", bus.dat, 16'h0000);
    for (int f = 0; f < 3; f++) run_frame(16'h0008, "hold 3");
    for (int f = 0; f < 3; f++) run_frame(16'h0208, "add 9");
    for (int f = 0; f < 3; f++) run_frame(16'h0000, "rel 3+9");
    check("3+9 dat", bus.dat, 16'h0003);
    check("3+9 key_code", 16'(bus.key_code), 16'h0003);

    // reset while A is held
    do_reset("reset A");
    for (int f = 0; f < 3; f++) run_frame(16'h0400, "hold A");
    repeat (15) @(negedge clk);
    rst = 1'b1;
    #1;
    check_reset_values("mid reset");
    repeat (3) @(negedge clk);
    rst = 1'b0;
    model_reset();
    for (int f = 0; f < 3; f++) run_frame(16'h0400, "A after rst");
    for (int f = 0; f < 3; f++) run_frame(16'h0000, "rel A");
    check("A dat", bus.dat, 16'h000A);
    check("A key_code", 16'(bus.key_code), 16'h000A);

    // random frames
    do_reset("reset rnd");
    k1 = 4'd0;
    for (int f = 0; f < 60; f++) begin
      sel = int'($urandom_range(0, 9));
      if (sel < 4) begin
        mask = 16'd0;
      end else if (sel < 9) begin
        if ($urandom_range(0, 9) < 3) k1 = 4'($urandom_range(0, 15));
        mask = 16'd1 << k1;
      end else begin
        k2   = k1 + 4'($urandom_range(1, 15));
        mask = (16'd1 << k1) | (16'd1 << k2);
      end
      run_frame(mask, "random");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/keypad_entry.md
# keypad_entry

Scans a 4x4 matrix hex keypad and assembles the debounced key presses into a 16-bit hex word. It uses the same 1 ms column time-slot scheme as the 7-segment display driver, but in the input direction: it drives one column low per slot and reads the rows. Its `dat`/`ptr_P` outputs connect directly to the display driver's `dat`/`ptr_P` inputs, so the operator can enter and see MIL-STD test words (command words, data words) from the board.

## Interface
- `Fclk`, 50000, clock frequency in kHz
- `F1kHz`, 1, column slot rate in kHz; the slot length is `Fclk/F1kHz` clocks
- `DEB`, 4, number of consecutive identical scan frames required to accept a press or a release (range 1..15)

- `clk`  in  1  system clock; the only clock
- `rst`  in  1  reset, asynchronous, active-high
- `COL`  out  4  column drive, active-low one-hot
- `ROW`  in  4  row sense, active-low (board pull-ups), asynchronous to `clk`
- `dat`  out  16  entered word; the newest digit is in `[3:0]`
- `ptr_P`  out  2  count of accepted digits, modulo 4
- `key_code`  out  4  code of the last accepted key
- `key_vld`  out  1  one-clock pulse on each accepted press
- `ce1ms`  out  1  one-clock pulse once per slot, registered

## Operation
- **Slot counter `cb_1ms`**
  - Resets to 0; counts up by 1 each clock.
  - `ce` = (`cb_1ms == Fclk/F1kHz`); on `ce` the counter reloads to 1.
  - `ce1ms` is `ce` delayed by one register.
- **Column counter `cb_col`** (2 bits)
  - Advances on `ce` and wraps 3 -> 0.
  - `COL = ~(4'b0001 << cb_col)`, registered.
- **Row synchronizer**: `ROW` passes through a 2-FF synchronizer, giving `row_s`.
- **Frame assembly**
  - On `ce`, `~row_s` is stored as frame bits for column `cb_col`. This is the value for the column driven during the slot now ending.
  - After the column-3 sample, `frame_rdy` pulses for one clock and the frame is decoded.
- **Frame decode** (key at row r, column c has code 4*r + c)
  - NONE: no bits set.
  - SINGLE: exactly one bit set; yields `code`.
  - MULTI: two or more bits set; never accepted as a press.
- **Debounce FSM** (4-bit counter `dcnt`, candidate register `cand`), evaluated only on `frame_rdy`:
  - IDLE
    - SINGLE -> DEB, with `cand`=`code` and `dcnt`=1. If `DEB`==1, accept immediately instead and go to PRESSED.
    - Otherwise stay in IDLE.
  - DEB
    - SINGLE with `code`==`cand`: `dcnt`+1. When the count reaches `DEB`, accept and go to PRESSED.
    - Any other frame -> IDLE.
  - PRESSED
    - NONE -> REL with `dcnt`=1 (if `DEB`==1, go straight to IDLE).
    - SINGLE or MULTI: stay in PRESSED. A second key added while one is held is ignored.
  - REL
    - NONE: `dcnt`+1. When the count reaches `DEB`, go to IDLE.
    - SINGLE or MULTI -> PRESSED.
- **Accept action**, all in the same clock:
  - `dat` <= {`dat[11:0]`, `cand`}
  - `ptr_P` <= `ptr_P` + 1 (wraps 3 -> 0)
  - `key_code` <= `cand`
  - `key_vld` <= 1 for one clock
- Exactly one `key_vld` is produced per press. Holding a key never auto-repeats.

## Timing
- **Reset values**
  - `COL`=4'b1110, `dat`=0, `ptr_P`=0, `key_code`=0, `key_vld`=0, `ce1ms`=0.
  - FSM in IDLE; `cb_1ms`, `cb_col`, frame, `dcnt`, `cand` and synchronizer all 0.
- **Scan period**: a full frame takes 4 slots, i.e. 4·`Fclk/F1kHz` clocks (4 ms at default settings).
- **Accept latency**
  - `frame_rdy` is high in the clock after the `ce` that samples column 3.
  - `key_vld`, `dat` and `ptr_P` update on the following edge, i.e. 2 clocks after that `ce`.
  - A clean press held from slot 0 is therefore accepted at the end of frame `DEB`.
- **Row settling**: each column is held for a full slot before it is sampled, so the 2-clock synchronizer delay is irrelevant.
- **Mid-operation reset**
  - `rst` asserted at any time forces the reset values immediately, independent of `clk`.
  - A key still held when `rst` is released is treated as a new press and is accepted once, after `DEB` frames.
- **Digit overflow**: the fifth and later digits shift the oldest digit out of `dat[15:12]` and discard it.

## Test plan
Bench parameters: `Fclk`=10, `F1kHz`=1 (slot of 10 clocks, frame of 40 clocks), `DEB`=2, key model pulling the matching row low whenever its column is driven low.
- Reset and idle: `rst` pulse with no keys -> all outputs at reset values; `COL` cycles 1110, 1101, 1011, 0111, changing every 10 clocks; `ce1ms` pulses every 10 clocks; no `key_vld` for 400 clocks.
- Single press: hold key row 2, column 3 for 6 frames, then release -> exactly one `key_vld` with `key_code`=4'hB, at the end of the second full frame; `dat`=16'h000B, `ptr_P`=1.
- Entry and overflow: press keys 1, 2, 3, 4, 5 in sequence, each pressed and released cleanly -> after the fourth press `dat`=16'h1234 and `ptr_P`=0; after the fifth `dat`=16'h2345 and `ptr_P`=1.
- Bounce: toggle key 7 on and off every frame for 5 frames, then hold it -> no `key_vld` during the bouncing; exactly one `key_vld`=7 after 2 stable frames; a single-frame release glitch while held produces no second pulse.
- Multi-key: press keys 0 and 5 together -> no `key_vld`; hold 3, then add 9 -> one `key_vld` with code 3 only.
- Reset mid-press: assert `rst` while key A is held in PRESSED -> outputs return to reset values at once; after `rst` is released, one `key_vld` with code 4'hA follows 2 frames later.
